// File: rtl/mul_seq_16.sv
// Iterative 16x16 unsigned shift-add multiplier, one CLA add per step, start/busy/done handshake.
// Define MUL_EARLY_TERM_EN to stop as soon as the remaining multiplier bits are all zero.

module mul_seq_16_cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s
);
  logic [3:0] g, pr;
  logic [3:1] c;

  assign g  = x & y;
  assign pr = x ^ y;
  assign c[1] = g[0] | (pr[0] & cin);
  assign c[2] = g[1] | (pr[1] & g[0]) | (pr[1] & pr[0] & cin);
  assign c[3] = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0]) | (pr[2] & pr[1] & pr[0] & cin);
  assign s  = pr ^ {c[3], c[2], c[1], cin};
endmodule

module mul_seq_16 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [2*WIDTH:0]   r;
  logic [WIDTH-1:0]   m;
  logic [4:0]         cnt;

  logic [WIDTH-1:0]   hi, lo, sum;
  logic [3:0]         gg, pg;
  logic [4:0]         gc;
  logic [WIDTH:0]     add_res;
  logic [2*WIDTH-1:0] step_r;

  assign hi = r[2*WIDTH-1:WIDTH];
  assign lo = r[WIDTH-1:0];

  // Group generate/propagate come straight from the operands so the
  // second-level lookahead never depends on the group sum logic.
  function automatic logic [1:0] grp_gp(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] gv, pv;
    gv = x & y;
    pv = x ^ y;
    return {gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1]) | (pv[3] & pv[2] & pv[1] & gv[0]), &pv};
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_cla
    assign {gg[i], pg[i]} = grp_gp(hi[4*i +: 4], m[4*i +: 4]);
    mul_seq_16_cla4 u_cla (
      .x  (hi[4*i +: 4]),
      .y  (m[4*i +: 4]),
      .cin(gc[i]),
      .s  (sum[4*i +: 4])
    );
  end

  assign gc[0] = 1'b0;
  assign gc[1] = gg[0] | (pg[0] & gc[0]);
  assign gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & gc[0]);
  assign gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & gc[0]);
  assign gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
               | (pg[3] & pg[2] & pg[1] & pg[0] & gc[0]);

  assign add_res = lo[0] ? {gc[4], sum} : {1'b0, hi};
  assign step_r  = {add_res, lo[WIDTH-1:1]};

`ifdef MUL_EARLY_TERM_EN
  logic [4:0]       k;
  logic [2*WIDTH:0] shifted;
  logic             lo_zero;
  logic             unused_bits;

  assign k       = 5'd16 - cnt;
  assign shifted = r >> k;
  assign lo_zero = (lo & (16'hFFFF >> cnt)) == '0;
  assign unused_bits = ^{r[2*WIDTH], shifted[2*WIDTH]};
`else
  logic unused_bits;
  assign unused_bits = r[2*WIDTH];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      r     <= '0;
      m     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r     <= {{(WIDTH+1){1'b0}}, b};
            m     <= a;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
`ifdef MUL_EARLY_TERM_EN
          if (lo_zero) begin
            p     <= shifted[2*WIDTH-1:0];
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else
`endif
          begin
            r   <= {1'b0, step_r};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd15) begin
              p     <= step_r;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_16.sv
// Scoreboard bench for mul_seq_16: products queued at start, compared on each done pulse.
module tb_mul_seq_16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] p;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] sb[$];
  logic [31:0] prev_p = '0;
  logic        prev_done = 1'b0;

  mul_seq_16 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .p    (p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] bv);
`ifdef MUL_EARLY_TERM_EN
    int h;
    h = -1;
    for (int i = 0; i < 16; i++) if (bv[i]) h = i;
    return (h + 2 > 16) ? 16 : h + 2;
`else
    return (bv == 16'h0) ? 16 : 16;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) chk("spurious_done", {31'b0, done}, 32'd0);
      else                chk("product", p, sb.pop_front());
      chk("done_width", {31'b0, prev_done}, 32'd0);
    end
    prev_done = rst_n && done;
  end

  // Starts one multiplication (in the current cycle when b2b, i.e. during DONE)
  // and waits for its done pulse; inj fires an ignored start during RUN.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input bit inj, input bit b2b);
    int          lat, bcyc;
    logic [31:0] e;
    e = 32'(ta) * 32'(tb);
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start = 1'b1; a = ta; b = tb;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", {31'b0, busy}, 32'd1);
    chk("p_hold", p, prev_p);
    lat = 0; bcyc = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      if (inj && lat == 0) begin
        start = 1'b1; a = 16'h0005; b = 16'h0005;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat(tb)));
    chk("busy_cycles", 32'(bcyc), 32'(exp_lat(tb)));
    chk("busy_fall", {31'b0, busy}, 32'd0);
    prev_p = e;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    a = 16'($urandom);
    b = 16'($urandom);
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_p", p, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_done", {31'b0, done}, 32'd0);
      chk("idle_p", p, 32'd0);
    end

    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("p_hold_idle", p, 32'hFFFE0001);

    do_op(16'h1234, 16'h0003, 1'b0, 1'b0);
    do_op(16'h00FF, 16'h0000, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("ignored_start_p", p, 32'd0);

    do_op(16'h0007, 16'h0009, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0002, 1'b0, 1'b1);

    @(posedge clk); #1;
    start = 1'b1; a = 16'h1111; b = 16'h0303;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_p", p, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_p = '0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_idle_busy", {31'b0, busy}, 32'd0);

    do_op(16'h0005, 16'h0005, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_op(16'($urandom), 16'($urandom), 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
